ysyx_22050039_lsu: RTL and testbench
====================================

# ysyx_22050039_lsu

Multi-cycle load/store unit that sits directly downstream of the execute stage. It accepts one memory operation per transaction: a decoded op code, an effective address and store data. It performs one 8-byte-aligned access on a valid/ready memory port. For loads it returns the lane-extracted, sign- or zero-extended result to writeback; for stores it returns a completion.

## Interface
- XLEN, 64, data/address width (only 64 supported)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  execute stage presents an operation
- in_ready  out  1  LSU can accept (high only in IDLE)
- in_op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size: 0 byte, 1 half, 2 word, 3 double
- in_addr  in  XLEN  effective address (src1+src2 from execute)
- in_wdata  in  XLEN  store data, right-aligned
- mem_req_valid  out  1  memory request pending
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  in_addr with bits [2:0] cleared
- mem_wen  out  1  1 = write
- mem_wdata  out  XLEN  store data shifted to lane
- mem_wmask  out  8  byte enables (0 for reads)
- mem_resp_valid  in  1  read data valid / write acknowledged
- mem_rdata  in  XLEN  8-byte-aligned read data
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes result
- out_rdata  out  XLEN  extended load result; 0 for stores and on misalign
- out_misalign  out  1  operation was misaligned; qualified by out_valid

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: in_ready=1. On in_valid, register op/addr/wdata.
  - Misaligned → DONE with misalign=1, no memory access.
  - Otherwise → REQ.
- Misaligned cases: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0. Byte accesses are never misaligned.
- REQ: mem_req_valid=1; mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready=1, then → RESP.
- RESP: wait for mem_resp_valid, then → DONE.
  - Loads capture the result.
  - Stores treat the response as an acknowledgment only.
  - mem_resp_valid is ignored in IDLE, REQ and DONE.
- DONE: out_valid=1; out_rdata/out_misalign held until out_ready=1, then → IDLE.
- Lane select: sh = addr[2:0]*8.
  - Loads extract mem_rdata >> sh, truncated to size.
  - Extension: sign-extend from bit 7/15/31 unless unsigned=1, then zero-extend. Double ignores the unsigned bit.
- Store mask: byte 8'h01<<addr[2:0]; half 8'h03<<addr[2:0]; word 8'h0F<<addr[2:0]; double 8'hFF.
- Store data: mem_wdata = in_wdata << sh. Bytes outside the mask are don't-care but must be deterministic.
- Unsigned bit on a store: ignored.

## Timing
- All outputs are registered or decoded purely from state plus registered fields. There is no combinational path from in_* to mem_* or out_*.
- Reset (rst=0 at a clk edge), from any state:
  - → IDLE.
  - in_ready=0 during reset, then 1 the first cycle after.
  - All other outputs 0.
  - A pending request or response is abandoned; a response arriving later in IDLE is ignored.
- Best-case latency, with mem_req_ready and mem_resp_valid both high at first opportunity:
  - accept at edge 0
  - REQ during cycle 1, handshake at edge 1
  - RESP cycle 2, response at edge 2
  - out_valid in cycle 3
  - IDLE again after edge 3 when out_ready=1
- Misaligned path: out_valid in the cycle after acceptance; mem_req_valid never asserted.
- One transaction in flight; no new acceptance until DONE completes.
- Response in the same cycle as the request handshake is not supported; the memory must respond no earlier than the following cycle.

## Test plan
- Signed byte load: op=0x0, addr=0x80000003, mem_rdata=0x00000000_80000000 → mem_addr=0x80000000, mem_wmask=0, out_rdata=0xFFFFFFFF_FFFFFF80, out_misalign=0.
- Unsigned half load: op=0x5, addr=0x80000006, mem_rdata=0xBEEF_0000_0000_0000 → out_rdata=0x000000000000BEEF. The same with op=0x1 → 0xFFFFFFFFFFFFBEEF.
- Word store at upper lane: op=0xA, addr=0x80000104, wdata=0x11223344 → mem_addr=0x80000100, mem_wen=1, mem_wmask=8'hF0, mem_wdata[63:32]=0x11223344, out_rdata=0.
- Misaligned word load: op=0x2, addr=0x80000002 → mem_req_valid stays 0, out_valid one cycle after accept, out_misalign=1, out_rdata=0.
- Backpressure: doubleword load with mem_req_ready low for 3 cycles and out_ready low for 2 cycles.
  - mem_* stable while stalled.
  - Exactly one request handshake.
  - out_rdata stable until consumed.
  - in_ready=0 throughout.
- Reset mid-op: assert rst=0 while in RESP, then drive mem_resp_valid in the next cycles → LSU in IDLE, out_valid never rises, and the next transaction completes normally.

Source files
------------

// File: rtl/ysyx_22050039_lsu_if.sv
// Handshake bundle between the LSU, the execute stage, the memory port and writeback.
// The LSU takes the slave view; the surrounding pipeline/memory take the master view.
interface ysyx_22050039_lsu_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic            out_misalign;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        input  out_ready,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output out_valid, out_rdata, out_misalign
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        output out_ready,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  out_valid, out_rdata, out_misalign
    );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// Multi-cycle load/store unit: one 8-byte-aligned memory access per transaction,
// lane extraction and sign/zero extension for loads, byte masks for stores.
module ysyx_22050039_lsu #(
    parameter int XLEN = 64
) (
    input logic                clk,
    input logic                rst,
    ysyx_22050039_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t     state;
    logic [3:0] op_q;
    logic [2:0] lane_q;
    logic       misalign;
    logic [7:0] wmask;
    logic [5:0] in_sh;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                               input logic [2:0] op);
        logic [XLEN-1:0] res;
        unique case (op[1:0])
            2'd0:    res = op[2] ? {{(XLEN-8){1'b0}},  raw[7:0]}
                                 : {{(XLEN-8){raw[7]}}, raw[7:0]};
            2'd1:    res = op[2] ? {{(XLEN-16){1'b0}},   raw[15:0]}
                                 : {{(XLEN-16){raw[15]}}, raw[15:0]};
            2'd2:    res = op[2] ? {{(XLEN-32){1'b0}},   raw[31:0]}
                                 : {{(XLEN-32){raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign in_sh = {bus.in_addr[2:0], 3'b000};

    always_comb begin
        misalign = 1'b0;
        wmask    = '0;
        unique case (bus.in_op[1:0])
            2'd0: begin misalign = 1'b0;                 wmask = 8'h01 << bus.in_addr[2:0]; end
            2'd1: begin misalign = bus.in_addr[0];       wmask = 8'h03 << bus.in_addr[2:0]; end
            2'd2: begin misalign = |bus.in_addr[1:0];    wmask = 8'h0F << bus.in_addr[2:0]; end
            default: begin misalign = |bus.in_addr[2:0]; wmask = 8'hFF;                     end
        endcase
    end

    // in_ready is a register so it stays low through reset and rises one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= IDLE;
            op_q              <= '0;
            lane_q            <= '0;
            bus.in_ready      <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_addr      <= '0;
            bus.mem_wen       <= 1'b0;
            bus.mem_wdata     <= '0;
            bus.mem_wmask     <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_rdata     <= '0;
            bus.out_misalign  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_ready && bus.in_valid) begin
                        op_q         <= bus.in_op;
                        lane_q       <= bus.in_addr[2:0];
                        bus.in_ready <= 1'b0;
                        if (misalign) begin
                            state            <= DONE;
                            bus.out_valid    <= 1'b1;
                            bus.out_misalign <= 1'b1;
                            bus.out_rdata    <= '0;
                        end else begin
                            state             <= REQ;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_addr      <= {bus.in_addr[XLEN-1:3], 3'b000};
                            bus.mem_wen       <= bus.in_op[3];
                            bus.mem_wmask     <= bus.in_op[3] ? wmask : 8'h00;
                            bus.mem_wdata     <= bus.in_op[3] ? (bus.in_wdata << in_sh) : '0;
                        end
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        state             <= RESP;
                        bus.mem_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (bus.mem_resp_valid) begin
                        state            <= DONE;
                        bus.out_valid    <= 1'b1;
                        bus.out_misalign <= 1'b0;
                        bus.out_rdata    <= op_q[3] ? '0
                                          : extend(bus.mem_rdata >> {lane_q, 3'b000}, op_q[2:0]);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for the LSU: loads/stores across lanes, misalignment,
// memory and writeback backpressure, and reset in the middle of a transaction.
module tb_ysyx_22050039_lsu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050039_lsu_if #(.XLEN(64)) bus ();
    ysyx_22050039_lsu #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass  = 0;
    int total = 0;

    logic [63:0] s_maddr, s_mwdata, s_rdata;
    logic [7:0]  s_wmask;
    logic        s_wen, s_mis;
    int          s_lat, s_hs, s_req_cycles;
    bit          e_mstable, e_ostable, e_inready, e_timeout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs one transaction from a negedge; memory answers the cycle after the handshake.
    task automatic run_txn(input string name, input logic [3:0] op, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata,
                           input int req_stall, input int out_stall);
        int  rstall = 0;
        int  ostall = 0;
        bit  pend   = 0;
        bit  done   = 0;
        s_maddr = '0; s_mwdata = '0; s_rdata = '0; s_wmask = '0; s_wen = 0; s_mis = 0;
        s_lat = 0; s_hs = 0; s_req_cycles = 0;
        e_mstable = 0; e_ostable = 0; e_inready = 0; e_timeout = 0;
        chk({name, ".idle_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_addr = addr; bus.in_wdata = wdata;
        bus.mem_rdata = rdata; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.in_ready !== 1'b0) e_inready = 1;
            bus.mem_resp_valid = pend;
            pend = 0;
            if (bus.mem_req_valid === 1'b1) begin
                if (s_req_cycles == 0) begin
                    s_maddr = bus.mem_addr; s_mwdata = bus.mem_wdata;
                    s_wmask = bus.mem_wmask; s_wen = bus.mem_wen;
                end else if (bus.mem_addr !== s_maddr || bus.mem_wdata !== s_mwdata ||
                             bus.mem_wmask !== s_wmask || bus.mem_wen !== s_wen) begin
                    e_mstable = 1;
                end
                s_req_cycles++;
                if (rstall < req_stall) begin
                    bus.mem_req_ready = 1'b0; rstall++;
                end else begin
                    bus.mem_req_ready = 1'b1; s_hs++; pend = 1;
                end
            end else begin
                bus.mem_req_ready = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                if (s_lat == 0) begin
                    s_lat = c; s_rdata = bus.out_rdata; s_mis = bus.out_misalign;
                end else if (bus.out_rdata !== s_rdata || bus.out_misalign !== s_mis) begin
                    e_ostable = 1;
                end
                if (ostall < out_stall) begin
                    bus.out_ready = 1'b0; ostall++;
                end else begin
                    bus.out_ready = 1'b1; done = 1;
                end
            end
            if (done) break;
            @(negedge clk);
        end
        if (!done) e_timeout = 1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        chk({name, ".timeout"}, 64'(e_timeout), 64'd0);
        chk({name, ".in_ready_busy"}, 64'(e_inready), 64'd0);
        chk({name, ".back_to_idle"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_op = '0; bus.in_addr = '0; bus.in_wdata = '0;
        bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0; bus.out_ready = 0;

        repeat (2) @(negedge clk);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst.out_rdata", bus.out_rdata, 64'd0);
        chk("rst.mem_wmask", 64'(bus.mem_wmask), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        run_txn("lb", 4'h0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
        chk("lb.mem_addr", s_maddr, 64'h8000_0000);
        chk("lb.mem_wmask", 64'(s_wmask), 64'h0);
        chk("lb.mem_wen", 64'(s_wen), 64'h0);
        chk("lb.rdata", s_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb.misalign", 64'(s_mis), 64'h0);
        chk("lb.latency", 64'(s_lat), 64'd3);
        chk("lb.handshakes", 64'(s_hs), 64'd1);

        run_txn("lhu", 4'h5, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 0);
        chk("lhu.rdata", s_rdata, 64'h0000_0000_0000_BEEF);
        run_txn("lh", 4'h1, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 0);
        chk("lh.rdata", s_rdata, 64'hFFFF_FFFF_FFFF_BEEF);

        run_txn("lwu", 4'h6, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 0);
        chk("lwu.rdata", s_rdata, 64'h0000_0000_89AB_CDEF);
        run_txn("lw", 4'h2, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 0);
        chk("lw.rdata", s_rdata, 64'hFFFF_FFFF_89AB_CDEF);
        run_txn("ld_u", 4'h7, 64'h8000_0008, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0);
        chk("ld_u.rdata", s_rdata, 64'hFEDC_BA98_7654_3210);

        run_txn("sw", 4'hA, 64'h8000_0104, 64'h1122_3344, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0);
        chk("sw.mem_addr", s_maddr, 64'h8000_0100);
        chk("sw.mem_wen", 64'(s_wen), 64'h1);
        chk("sw.mem_wmask", 64'(s_wmask), 64'hF0);
        chk("sw.mem_wdata_hi", 64'(s_mwdata[63:32]), 64'h1122_3344);
        chk("sw.rdata", s_rdata, 64'h0);
        chk("sw.misalign", 64'(s_mis), 64'h0);

        run_txn("sb", 4'h8, 64'h8000_0207, 64'hAB, 64'h0, 0, 0);
        chk("sb.mem_wmask", 64'(s_wmask), 64'h80);
        chk("sb.mem_wdata_hi", 64'(s_mwdata[63:56]), 64'hAB);
        run_txn("sd", 4'hB, 64'h8000_0310, 64'h0102_0304_0506_0708, 64'h0, 0, 0);
        chk("sd.mem_wmask", 64'(s_wmask), 64'hFF);
        chk("sd.mem_wdata", s_mwdata, 64'h0102_0304_0506_0708);
        chk("sd.mem_addr", s_maddr, 64'h8000_0310);

        run_txn("mis_w", 4'h2, 64'h8000_0002, 64'h0, 64'h0, 0, 0);
        chk("mis_w.req_cycles", 64'(s_req_cycles), 64'd0);
        chk("mis_w.latency", 64'(s_lat), 64'd1);
        chk("mis_w.misalign", 64'(s_mis), 64'h1);
        chk("mis_w.rdata", s_rdata, 64'h0);
        run_txn("mis_h", 4'h1, 64'h8000_0005, 64'h0, 64'h0, 0, 0);
        chk("mis_h.misalign", 64'(s_mis), 64'h1);
        chk("mis_h.req_cycles", 64'(s_req_cycles), 64'd0);

        run_txn("bp", 4'h3, 64'h8000_0018, 64'h0, 64'h0123_4567_89AB_CDEF, 3, 2);
        chk("bp.mem_addr", s_maddr, 64'h8000_0018);
        chk("bp.mem_stable", 64'(e_mstable), 64'd0);
        chk("bp.req_cycles", 64'(s_req_cycles), 64'd4);
        chk("bp.handshakes", 64'(s_hs), 64'd1);
        chk("bp.out_stable", 64'(e_ostable), 64'd0);
        chk("bp.rdata", s_rdata, 64'h0123_4567_89AB_CDEF);
        chk("bp.latency", 64'(s_lat), 64'd6);

        // Reset while waiting in RESP; a stale response must not produce a result.
        bus.in_valid = 1'b1; bus.in_op = 4'h3; bus.in_addr = 64'h8000_0020;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rmo.req_valid", 64'(bus.mem_req_valid), 64'd1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rmo.rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rmo.rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rmo.rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1; bus.mem_rdata = '1;
        @(negedge clk);
        chk("rmo.in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("rmo.out_valid_1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("rmo.out_valid_2", 64'(bus.out_valid), 64'd0);
        bus.mem_resp_valid = 1'b0;

        run_txn("post", 4'h4, 64'h8000_0031, 64'h0, 64'h0000_0000_0000_9A00, 0, 0);
        chk("post.rdata", s_rdata, 64'h0000_0000_0000_009A);
        chk("post.latency", 64'(s_lat), 64'd3);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
